adc_mod_mapper: RTL and testbench

- Parametrised successor to the per-word ADC-to-DDS mapper.
- Selects one of NUM_CH ADC channels and averages 2^AVG_LOG2 samples per window.
- Maps the averaged sample to a DDS control word: out = center ± kf·|avg − zero_cal|, with optional saturation and a sticky overflow flag.
- Parameters take effect only at window boundaries. One instance drives one DDS word (frequency, phase or amplitude).

---
 rtl/adc_mod_mapper.sv | 103 ++++++++++
 tb/tb_adc_mod_mapper.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_mod_mapper.sv
// adc_mod_mapper: averages one selected ADC channel per window and maps it to a DDS control word
module adc_mod_mapper #(
  parameter int ADC_WIDTH = 12,
  parameter int NUM_CH    = 4,
  parameter int AVG_LOG2  = 2,
  parameter int KF_WIDTH  = 32,
  parameter int OUT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        param_wen,
  input  logic [OUT_WIDTH-1:0]        center,
  input  logic [KF_WIDTH-1:0]         kf,
  input  logic [3:0]                  ch_sel,
  input  logic [ADC_WIDTH-1:0]        zero_cal,
  input  logic                        sat_en,
  input  logic                        adc_en,
  input  logic                        adc_valid,
  input  logic [NUM_CH*ADC_WIDTH-1:0] adc_data,
  output logic [OUT_WIDTH-1:0]        out_word,
  output logic                        out_valid,
  output logic                        overflow
);
  localparam int AW  = ADC_WIDTH + AVG_LOG2;
  localparam int CW  = AVG_LOG2 + 1;
  localparam int PW  = KF_WIDTH + ADC_WIDTH;
  localparam int OW1 = OUT_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
  logic [OUT_WIDTH-1:0] p_center, a_center, c0, c1, c2;
  logic [KF_WIDTH-1:0]  p_kf, a_kf, k0, k1;
  logic [3:0]           p_ch, a_ch;
  logic [ADC_WIDTH-1:0] p_zero, a_zero, z0, avg0, mag1, sample;
  logic                 p_sat, a_sat, p_flag, s0, s1, s2, neg1, neg2;
  logic                 take, last, load, v0, v1, v2, prod_hi, ovf;
  logic [AW-1:0]        acc, acc_sum;
  logic [CW-1:0]        cnt;
  logic [PW-1:0]        prod2;
  logic [OW1-1:0]       prod_x, sum;
  logic [OUT_WIDTH-1:0] res;
  // accept/window-end/shadow-load decode and channel selection
  always_comb begin
    take    = adc_valid & adc_en;
    last    = take & (cnt == LAST);
    load    = p_flag & (last | ~adc_en);
    sample  = (32'(a_ch) < NUM_CH) ? adc_data[a_ch*ADC_WIDTH +: ADC_WIDTH] : '0;
    acc_sum = acc + AW'(sample);
  end
  // pending set captures writes; active set only changes at window boundaries or while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      {p_center, p_kf, p_ch, p_zero, p_sat, p_flag} <= '0;
      {a_center, a_kf, a_ch, a_zero, a_sat} <= '0;
    end else begin
      if (load) {a_center, a_kf, a_ch, a_zero, a_sat} <= {p_center, p_kf, p_ch, p_zero, p_sat};
      if (param_wen) {p_center, p_kf, p_ch, p_zero, p_sat} <= {center, kf, ch_sel, zero_cal, sat_en};
      p_flag <= param_wen | (p_flag & ~load);
    end
  end
  // accumulator, sample counter and pipeline valids
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      {v0, v1, v2} <= '0;
    end else begin
      acc <= (~adc_en | last) ? '0 : take ? acc_sum : acc;
      cnt <= (~adc_en | last) ? '0 : take ? cnt + 1'b1 : cnt;
      {v0, v1, v2} <= {last, v0, v1};
    end
  end
  // datapath: average plus a snapshot of the active set travels with each window result
  always_ff @(posedge clk) begin
    if (last) begin
      avg0 <= ADC_WIDTH'(acc_sum >> AVG_LOG2);
      {z0, k0, c0, s0} <= {a_zero, a_kf, a_center, a_sat};
    end
    neg1  <= avg0 < z0;
    mag1  <= (avg0 < z0) ? z0 - avg0 : avg0 - z0;
    {k1, c1, s1} <= {k0, c0, s0};
    prod2 <= PW'(k1) * PW'(mag1);
    {neg2, c2, s2} <= {neg1, c1, s1};
  end
  // final add/subtract with range check, clamp or wrap
  always_comb begin
    prod_hi = (prod2 >> OUT_WIDTH) != '0;
    prod_x  = OW1'(OUT_WIDTH'(prod2));
    sum     = neg2 ? {1'b0, c2} - prod_x : {1'b0, c2} + prod_x;
    ovf     = prod_hi | sum[OUT_WIDTH];
    res     = (ovf & s2) ? (neg2 ? '0 : '1) : sum[OUT_WIDTH-1:0];
  end
  // output register and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      out_word  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) out_word <= res;
      overflow <= (overflow & ~param_wen) | (v2 & ovf);
    end
  end
endmodule

// File: tb/tb_adc_mod_mapper.sv
// tb_adc_mod_mapper: directed plan plus randomized traffic against a window-level reference model
module tb_adc_mod_mapper;
  localparam int AW = 12;
  localparam int N  = 4;
  localparam int NS = 4;
  localparam longint MAX = 64'h0000_0000_FFFF_FFFF;
  typedef struct {int due; longint w; bit o;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic param_wen = 1'b0;
  logic [31:0] center = '0;
  logic [31:0] kf = '0;
  logic [3:0] ch_sel = '0;
  logic [AW-1:0] zero_cal = '0;
  logic sat_en = 1'b0;
  logic adc_en = 1'b0;
  logic adc_valid = 1'b0;
  logic [N*AW-1:0] adc_data = '0;
  logic [31:0] out_word;
  logic out_valid, overflow;
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulses = 0;
  longint p_c, p_k, a_c, a_k, m_out;
  int p_ch, a_ch, p_z, a_z;
  bit p_s, a_s, pf, m_vld, m_ov;
  int win[$];
  res_t pq[$];

  always #5 clk = ~clk;

  adc_mod_mapper dut (
    .clk(clk), .rst(rst), .param_wen(param_wen), .center(center), .kf(kf),
    .ch_sel(ch_sel), .zero_cal(zero_cal), .sat_en(sat_en), .adc_en(adc_en),
    .adc_valid(adc_valid), .adc_data(adc_data), .out_word(out_word),
    .out_valid(out_valid), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic res_t mapw(int avg, int z, longint c, longint k, bit s, int due);
    res_t r;
    longint v;
    v = c + k * longint'(avg - z);
    r.due = due;
    r.o = (v < 0) || (v > MAX);
    r.w = !r.o ? v : s ? ((v < 0) ? 0 : MAX) : (v & MAX);
    return r;
  endfunction

  task automatic model();
    res_t r;
    int smp, sum;
    bit take, load;
    cyc++;
    if (rst) begin
      {p_c, p_k, a_c, a_k, m_out} = '0;
      {p_ch, a_ch, p_z, a_z} = '0;
      {p_s, a_s, pf, m_vld, m_ov} = '0;
      win.delete();
      pq.delete();
      return;
    end
    m_vld = 0;
    if (param_wen) m_ov = 0;
    if (pq.size() > 0) begin
      if (pq[0].due == cyc) begin
        r = pq.pop_front();
        m_vld = 1;
        m_out = r.w;
        if (r.o) m_ov = 1;
      end
    end
    take = adc_valid && adc_en;
    load = pf && (!adc_en || (take && win.size() == NS - 1));
    if (take) begin
      smp = (a_ch < N) ? int'(adc_data[a_ch*AW +: AW]) : 0;
      win.push_back(smp);
      if (win.size() == NS) begin
        sum = 0;
        foreach (win[i]) sum += win[i];
        pq.push_back(mapw(sum / NS, a_z, a_c, a_k, a_s, cyc + 3));
        win.delete();
      end
    end
    if (!adc_en) win.delete();
    if (load) begin
      {a_c, a_k, a_ch, a_z, a_s} = {p_c, p_k, p_ch, p_z, p_s};
      pf = 0;
    end
    if (param_wen) begin
      p_c = longint'(center);
      p_k = longint'(kf);
      p_ch = int'(ch_sel);
      p_z = int'(zero_cal);
      p_s = sat_en;
      pf = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    if (out_valid === 1'b1) pulses++;
    chk("out_valid", 64'(out_valid), 64'(m_vld));
    chk("out_word", 64'(out_word), m_out);
    chk("overflow", 64'(overflow), 64'(m_ov));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic setp(input longint c, input longint k, input int ch, input int z, input bit s);
    center = 32'(c);
    kf = 32'(k);
    ch_sel = 4'(ch);
    zero_cal = AW'(z);
    sat_en = s;
    param_wen = 1'b1;
    tick();
    param_wen = 1'b0;
  endtask

  task automatic samp(input int ch, input int v, input int n);
    adc_valid = 1'b1;
    for (int i = 0; i < N; i++) adc_data[i*AW +: AW] = (i == ch) ? AW'(v) : AW'(4000);
    repeat (n) tick();
    adc_valid = 1'b0;
  endtask

  task automatic cfg(input longint c, input longint k, input int ch, input int z, input bit s);
    adc_en = 1'b0;
    setp(c, k, ch, z, s);
    idle(1);
    adc_en = 1'b1;
  endtask

  initial begin
    int p0;
    bit due;
    idle(2);
    chk("rst_word", 64'(out_word), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ovf", 64'(overflow), 0);
    rst = 1'b0;
    cfg(1000, 10, 1, 100, 0);
    samp(1, 100, 1); samp(1, 102, 1); samp(1, 104, 1); samp(1, 106, 1);
    idle(2);
    chk("basic_early", 64'(out_valid), 0);
    idle(1);
    chk("basic_valid", 64'(out_valid), 1);
    chk("basic_word", 64'(out_word), 1030);
    chk("basic_ovf", 64'(overflow), 0);
    samp(1, 90, 4);
    idle(3);
    chk("neg_word", 64'(out_word), 900);
    cfg(5, 10, 1, 100, 1);
    samp(1, 0, 4);
    idle(3);
    chk("sat_word", 64'(out_word), 0);
    chk("sat_ovf", 64'(overflow), 1);
    adc_en = 1'b0;
    setp(5, 10, 1, 100, 0);
    chk("ovf_clear", 64'(overflow), 0);
    idle(1);
    adc_en = 1'b1;
    samp(1, 0, 4);
    idle(3);
    chk("wrap_word", 64'(out_word), 64'hFFFF_FC1D);
    chk("wrap_ovf", 64'(overflow), 1);
    cfg(1000, 10, 1, 100, 0);
    samp(1, 110, 2);
    setp(1000, 20, 1, 100, 0);
    samp(1, 110, 2);
    idle(3);
    chk("bound_old", 64'(out_word), 1100);
    samp(1, 110, 4);
    idle(3);
    chk("bound_new", 64'(out_word), 1200);
    cfg(500, 3, 7, 0, 0);
    samp(1, 999, 4);
    idle(3);
    chk("chan_range", 64'(out_word), 500);
    samp(0, 50, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_word", 64'(out_word), 0);
    p0 = pulses;
    samp(0, 50, 3);
    idle(4);
    chk("mid_rst_nopulse", 64'(pulses - p0), 0);
    samp(0, 50, 1);
    idle(3);
    chk("mid_rst_valid", 64'(out_valid), 1);
    cfg(0, 1, 0, 0, 0);
    p0 = pulses;
    samp(0, 200, 3);
    adc_en = 1'b0;
    tick();
    adc_en = 1'b1;
    samp(0, 200, 4);
    idle(3);
    chk("gate_word", 64'(out_word), 200);
    chk("gate_pulses", 64'(pulses - p0), 1);
    for (int it = 0; it < 4000; it++) begin
      due = 0;
      if (pq.size() > 0) due = (pq[0].due == cyc + 1);
      rst = ($urandom_range(0, 599) == 0);
      param_wen = !due && ($urandom_range(0, 15) == 0);
      center = $urandom();
      kf = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 3000));
      ch_sel = ($urandom_range(0, 4) == 0) ? 4'($urandom()) : 4'($urandom_range(0, 3));
      zero_cal = AW'($urandom());
      sat_en = 1'($urandom());
      adc_en = $urandom_range(0, 11) != 0;
      adc_valid = $urandom_range(0, 9) < 7;
      adc_data = (N*AW)'({$urandom(), $urandom()});
      tick();
    end
    rst = 1'b0;
    param_wen = 1'b0;
    adc_valid = 1'b0;
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
